// File: rtl/matmul_pkg.sv
// ============================================================================
// Module      : matmul_pkg
// Description : Shared types, matrix base addresses and element address helper
//               for the sequential 3x3 matrix multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matmul_pkg;

  localparam int N      = 3;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 17;

  localparam logic [ADDR_W-1:0] A_BASE = 17'h00200;
  localparam logic [ADDR_W-1:0] B_BASE = 17'h00300;
  localparam logic [ADDR_W-1:0] C_BASE = 17'h00100;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_C = 3'd3,
    DONE = 3'd4
  } state_t;

  // Row-major byte address of element [r][c]: base + 4*(3*r + c)
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [1:0] r,
                                                  input logic [1:0] c);
    logic [3:0] idx;
    idx = 4'(r) * 4'd3 + 4'(c);
    return base + {11'b0, idx, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_unit.sv
// ============================================================================
// Module      : mac_unit
// Description : Multiply-accumulate for one C element. MATMUL_SAT_EN selects a
//               64-bit product/accumulator with the result clamped to 32 bits;
//               otherwise products and sums wrap modulo 2^32.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_unit
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] result
);

`ifdef MATMUL_SAT_EN
  logic [2*WORD_W-1:0] acc;
  logic [2*WORD_W-1:0] prod;
  logic [2*WORD_W:0]   sum;

  assign prod = {{WORD_W{1'b0}}, a} * {{WORD_W{1'b0}}, b};
  assign sum  = {1'b0, acc} + {1'b0, prod};

  // A carry out of 64 bits is already far above the clamp, so stick at all-ones
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[2*WORD_W] ? {2*WORD_W{1'b1}} : sum[2*WORD_W-1:0];
    end
  end

  assign result = (acc[2*WORD_W-1:WORD_W] != '0) ? {WORD_W{1'b1}} : acc[WORD_W-1:0];
`else
  logic [WORD_W-1:0] acc;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + a * b;
    end
  end

  assign result = acc;
`endif

endmodule

`default_nettype wire

// File: rtl/matmul_seq.sv
// ============================================================================
// Module      : matmul_seq
// Description : Sequential 3x3 matrix multiply C = A x B over a single-port
//               memory. Optional saturating arithmetic via MATMUL_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_seq
  import matmul_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              memread,
  output logic              memwrite,
  output logic [ADDR_W-1:0] address,
  output logic [WORD_W-1:0] data_out,
  input  logic [WORD_W-1:0] data_in
);

  localparam logic [1:0] LAST = 2'(N - 1);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        i;
  logic [1:0]        j;
  logic [1:0]        k;
  logic [WORD_W-1:0] a_reg;
  logic [WORD_W-1:0] mac_result;
  logic              mac_clr;
  logic              mac_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      a_reg <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            i <= '0;
            j <= '0;
            k <= '0;
          end
        end
        RD_A: a_reg <= data_in;
        RD_B: begin
          if (k != LAST) k <= k + 2'd1;
        end
        WR_C: begin
          k <= '0;
          if (j == LAST) begin
            j <= '0;
            i <= (i == LAST) ? 2'd0 : i + 2'd1;
          end else begin
            j <= j + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    memread   = 1'b0;
    memwrite  = 1'b0;
    address   = '0;
    data_out  = '0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RD_A;
      end
      RD_A: begin
        memread   = 1'b1;
        address   = elem_addr(A_BASE, i, k);
        state_nxt = RD_B;
      end
      RD_B: begin
        memread   = 1'b1;
        address   = elem_addr(B_BASE, k, j);
        state_nxt = (k == LAST) ? WR_C : RD_A;
      end
      WR_C: begin
        memwrite  = 1'b1;
        address   = elem_addr(C_BASE, i, j);
        data_out  = mac_result;
        state_nxt = (i == LAST && j == LAST) ? DONE : RD_A;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign mac_en  = (state == RD_B);
  // Clear after each write and again on start so a new run never inherits a sum
  assign mac_clr = (state == WR_C) || (state == IDLE && start);

  mac_unit u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr    (mac_clr),
    .en     (mac_en),
    .a      (a_reg),
    .b      (data_in),
    .result (mac_result)
  );

endmodule

`default_nettype wire

// File: tb/tb_matmul_seq.sv
// ============================================================================
// Module      : tb_matmul_seq
// Description : Directed self-checking bench for matmul_seq with a behavioural
//               word memory (honours MATMUL_SAT_EN for the overflow case).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        memread;
  logic        memwrite;
  logic [16:0] address;
  logic [31:0] data_out;
  logic [31:0] data_in;

  logic [31:0] mem [0:32767];
  int          wr_cnt;
  logic [16:0] wr_addr [$];
  logic [31:0] wr_data [$];

  int n_cmp = 0;
  int n_err = 0;

`ifdef MATMUL_SAT_EN
  localparam logic [31:0] OVF_EXP = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] OVF_EXP = 32'hFFFF_FFFA;
`endif

  matmul_seq dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .memread  (memread),
    .memwrite (memwrite),
    .address  (address),
    .data_out (data_out),
    .data_in  (data_in)
  );

  always #5 clk = ~clk;

  assign data_in = memread ? mem[address[16:2]] : 32'h0;

  always @(posedge clk) begin
    if (memwrite) begin
      mem[address[16:2]] <= data_out;
      wr_cnt <= wr_cnt + 1;
      wr_addr.push_back(address);
      wr_data.push_back(data_out);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] a [9], input logic [31:0] b [9]);
    for (int m = 0; m < 9; m++) begin
      mem[(17'h00200 >> 2) + m] = a[m];
      mem[(17'h00300 >> 2) + m] = b[m];
      mem[(17'h00100 >> 2) + m] = 32'hDEAD_BEEF;
    end
  endtask

  // Pulse start; returns the cycle (edge 0 = start sampled) in which done rose
  task automatic run_mm(output int dc);
    dc = -1;
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 1) check("busy_c1", busy, 1);
      if (memread && memwrite) check("strobe_excl", 1, 0);
      if (done && dc < 0) dc = c;
      if (dc > 0 && c == dc + 1) begin
        check("busy_after_done", busy, 0);
        break;
      end
    end
    if (dc < 0) check("done_timeout", 0, 1);
  endtask

  logic [31:0] a_seq [9];
  logic [31:0] b_id  [9];
  logic [31:0] b_seq [9];
  logic [31:0] c_gen [9];
  logic [31:0] a_ovf [9];
  logic [31:0] b_ovf [9];

  initial begin
    int dc;
    int prev_done;
    int wr_seen;
    int busy_seen;

    a_seq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
    b_id  = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1};
    b_seq = a_seq;
    c_gen = '{32'd30, 32'd36, 32'd42, 32'd66, 32'd81, 32'd96, 32'd102, 32'd126, 32'd150};
    for (int m = 0; m < 9; m++) begin
      a_ovf[m] = 32'hFFFF_FFFF;
      b_ovf[m] = 32'd2;
    end

    wr_cnt = 0;
    reset  = 1'b1;
    start  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_memread", memread, 0);
    check("rst_memwrite", memwrite, 0);
    check("rst_address", address, 0);
    check("rst_data_out", data_out, 0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Identity: C = A, written in row-major order, done 64 cycles after start
    load(a_seq, b_id);
    run_mm(dc);
    check("id_done_cycle", dc, 64);
    check("id_wr_count", wr_addr.size(), 9);
    for (int m = 0; m < 9 && m < wr_addr.size(); m++) begin
      check($sformatf("id_wr_addr%0d", m), wr_addr[m], 17'h00100 + 17'(4 * m));
      check($sformatf("id_wr_data%0d", m), wr_data[m], m + 1);
    end

    // General product
    load(a_seq, b_seq);
    run_mm(dc);
    check("gen_done_cycle", dc, 64);
    for (int m = 0; m < 9; m++)
      check($sformatf("gen_c%0d", m), mem[(17'h00100 >> 2) + m], c_gen[m]);

    // Overflow
    load(a_ovf, b_ovf);
    run_mm(dc);
    for (int m = 0; m < 9; m++)
      check($sformatf("ovf_c%0d", m), mem[(17'h00100 >> 2) + m], OVF_EXP);

    // Reset at cycle 20: writes happened in cycles 7 and 14 only
    for (int m = 0; m < 9; m++) mem[(17'h00100 >> 2) + m] = 32'hDEAD_BEEF;
    @(negedge clk) begin
      wr_cnt = 0;
      start  = 1'b1;
    end
    @(negedge clk) start = 1'b0;
    for (int c = 2; c <= 20; c++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst21_busy", busy, 0);
    check("rst21_outs", {done, memread, memwrite, address, data_out}, 0);
    reset = 1'b0;
    wr_seen   = 0;
    busy_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (memwrite) wr_seen++;
      if (busy) busy_seen++;
    end
    check("rst_no_write", wr_seen, 0);
    check("rst_no_busy", busy_seen, 0);
    check("rst_wr_count", wr_cnt, 2);
    check("rst_c0_kept", mem[(17'h00100 >> 2)], OVF_EXP);
    check("rst_c2_untouched", mem[(17'h00100 >> 2) + 2], 32'hDEAD_BEEF);

    // Start held high: runs separated by exactly one IDLE cycle
    prev_done = -1;
    start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      check("hold_strobe_excl", {31'b0, memread && memwrite}, 0);
      if (prev_done >= 0 && c == prev_done + 1) check("hold_idle_gap", busy, 0);
      if (prev_done >= 0 && c == prev_done + 2) check("hold_restart", memread, 1);
      if (done) begin
        if (prev_done >= 0) check("hold_period", c - prev_done, 65);
        prev_done = c;
      end
    end
    check("hold_saw_done", {31'b0, prev_done >= 0}, 1);
    start = 1'b0;
    begin
      int t;
      t = 0;
      while (busy && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("hold_drain", busy, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 Clocking SHALL be a single clock; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin one 3x3 multiply C = A x B; sampled only in IDLE.
REQ-005 busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive.
REQ-006 done  output  1  one-cycle pulse when C is fully written.
REQ-007 memread  output  1  read strobe to main memory.
REQ-008 memwrite  output  1  write strobe to main memory.
REQ-009 address  output  17  byte address to main memory.
REQ-010 data_out  output  32  write data to memory data_in.
REQ-011 data_in  input  32  read data from memory data_out; combinational, valid in the same cycle as memread.

Function
REQ-012 Matrices SHALL be row-major 3x3 unsigned 32-bit words: A at 17'h00200, B at 17'h00300, C at 17'h00100; element [r][c] SHALL be at base + 4*(3*r+c).
REQ-013 States SHALL be IDLE, RD_A, RD_B, WR_C, DONE.
REQ-014 IDLE -> RD_A on start=1, with i=j=k=0 and acc=0; start SHALL be ignored in every other state.
REQ-015 In RD_A: memread=1 and address=A[i][k]; a_reg SHALL capture data_in at the clock edge; next state RD_B.
REQ-016 In RD_B: memread=1 and address=B[k][j]; acc SHALL be updated to acc + a_reg*data_in at the edge. If k<2: k increments and next state is RD_A. If k=2: next state is WR_C.
REQ-017 In WR_C: memwrite=1, address=C[i][j], data_out=acc. On the edge, acc and k SHALL clear and (i,j) SHALL advance row-major. After (2,2), next state is DONE; otherwise next state is RD_A.
REQ-018 In DONE: done=1 for one cycle; next state is IDLE.
REQ-019 memread and memwrite SHALL never be high in the same cycle. Whenever a strobe is low, address and data_out SHALL be 0 unless that strobe's state drives them.
REQ-020 Latency: start sampled at edge 0 gives 63 memory cycles (cycles 1-63) and done=1 in cycle 64. The block SHALL be ready for the next start in cycle 65.
REQ-021 With start held high continuously, a new run SHALL begin from the first IDLE cycle after DONE.
REQ-022 Default arithmetic: the product SHALL be the low 32 bits of 32x32, and the sum SHALL wrap mod 2^32.

Reset
REQ-023 While reset=1, the following SHALL be 0 at the next edge: state IDLE, i, j, k, acc, a_reg, busy, done, memread, memwrite, address, data_out.
REQ-024 Reset asserted mid-run SHALL abort the run with no further write; partially written C SHALL be left as is.
REQ-025 reset and start high together SHALL resolve to reset.

Configuration
REQ-026 Macro MATMUL_SAT_EN defined: the product SHALL be the full 64 bits and the accumulation 64 bits, with the written value clamped to 32'hFFFF_FFFF if the accumulation exceeds it.
REQ-027 MATMUL_SAT_EN undefined: arithmetic SHALL be per REQ-022, and no 64-bit datapath SHALL exist.

Structure
REQ-028 Package matmul_pkg SHALL hold the state enum, A_BASE/B_BASE/C_BASE, N=3, and WORD_W=32.
REQ-029 Sub-module mac_unit SHALL hold the multiply-accumulate (acc register, clear, enable, saturation under MATMUL_SAT_EN). The FSM and address generation SHALL stay in matmul_seq.

Verification
REQ-030 Identity case: A=1..9, B=identity, pulse start -> writes 1..9 to 17'h00100..17'h00120 in order, and done=1 exactly 64 cycles after start.
REQ-031 General case: A=1..9, B=1..9 -> C = 30,36,42,66,81,96,102,126,150.
REQ-032 Overflow case: all A=32'hFFFF_FFFF, all B=2 -> every C=32'hFFFF_FFFA without MATMUL_SAT_EN, and 32'hFFFF_FFFF with it.
REQ-033 Reset at cycle 20 of a run -> from cycle 21 all outputs are 0, no memwrite until the next start, and busy=0.
REQ-034 Start held high for 200 cycles -> back-to-back runs with one IDLE cycle between them. Check on every cycle: memread and memwrite never both high, and start pulses during busy have no effect.
